// File: rtl/upsample_pkg.sv
// Shared encodings and default dimensions for the 2x upsample frame sequencer.
package upsample_pkg;

    localparam int DEF_IMG_WIDTH  = 800;
    localparam int DEF_IMG_HEIGHT = 600;
    localparam int DEF_CNT_W      = 11;

    // Output mux selects understood by the upsample datapath
    localparam logic [1:0] SEL_LIVE = 2'd0;
    localparam logic [1:0] SEL_HOLD = 2'd1;
    localparam logic [1:0] SEL_LINE = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LIVE_P0   = 3'd1,
        ST_LIVE_P1   = 3'd2,
        ST_REPLAY_P0 = 3'd3,
        ST_REPLAY_P1 = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

endpackage

// File: rtl/upsample_pos_counter.sv
// Output column/row tracker for the doubled frame; the row wraps to zero after
// the last pixel so the next frame starts at the origin.
module upsample_pos_counter
    import upsample_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] col_q,
    output logic [CNT_W-1:0] row_q,
    output logic             last_col,
    output logic             last_pix
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(2 * IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(2 * IMG_HEIGHT - 1);

    logic [CNT_W-1:0] col_d;
    logic [CNT_W-1:0] row_d;

    assign last_col = (col_q == COL_LAST);
    assign last_pix = last_col && (row_q == ROW_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (en) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_pix ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/upsample_frame_ctrl.sv
// Sequencer for the 2x pixel/line-duplicating upsampler: even output rows come
// from the FIFO (live + hold), odd output rows replay the stored line.
module upsample_frame_ctrl
    import upsample_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             in_empty,
    output logic             in_rd_en,
    output logic             cap_en,
    output logic             line_rd_en,
    output logic [1:0]       out_sel,
    input  logic             out_afull,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_col,
    output logic [CNT_W-1:0] out_row
);

    state_t state_q;
    state_t state_d;
    logic   last_col;
    logic   last_pix;

    upsample_pos_counter #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT),
        .CNT_W     (CNT_W)
    ) u_pos (
        .clk     (clk),
        .rst     (rst),
        .en      (out_valid),
        .col_q   (out_col),
        .row_q   (out_row),
        .last_col(last_col),
        .last_pix(last_pix)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Strobes are a pure function of state and the two flow-control inputs,
    // so out_afull gates every strobe in the same cycle it rises.
    always_comb begin
        state_d    = state_q;
        in_rd_en   = 1'b0;
        cap_en     = 1'b0;
        line_rd_en = 1'b0;
        out_valid  = 1'b0;
        out_sel    = SEL_LIVE;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LIVE_P0;
                end
            end
            ST_LIVE_P0: begin
                if (!in_empty && !out_afull) begin
                    out_valid = 1'b1;
                    out_sel   = SEL_LIVE;
                    in_rd_en  = 1'b1;
                    cap_en    = 1'b1;
                    state_d   = ST_LIVE_P1;
                end
            end
            ST_LIVE_P1: begin
                if (!out_afull) begin
                    out_valid = 1'b1;
                    out_sel   = SEL_HOLD;
                    state_d   = last_col ? ST_REPLAY_P0 : ST_LIVE_P0;
                end
            end
            ST_REPLAY_P0: begin
                if (!out_afull) begin
                    out_valid  = 1'b1;
                    out_sel    = SEL_LINE;
                    line_rd_en = 1'b1;
                    state_d    = ST_REPLAY_P1;
                end
            end
            ST_REPLAY_P1: begin
                if (!out_afull) begin
                    out_valid = 1'b1;
                    out_sel   = SEL_HOLD;
                    if (last_pix) begin
                        state_d = ST_DONE;
                    end else if (last_col) begin
                        state_d = ST_LIVE_P0;
                    end else begin
                        state_d = ST_REPLAY_P0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_upsample_frame_ctrl.sv
// Directed bench for upsample_frame_ctrl: a small frame exercised for stalls,
// restarts and reset, plus a mid-sized frame for whole-frame counts.
module tb_upsample_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int W2 = 20;
    localparam int H2 = 15;
    localparam int CW = 11;

    localparam logic [1:0] E_LIVE = 2'd0;
    localparam logic [1:0] E_HOLD = 2'd1;
    localparam logic [1:0] E_LINE = 2'd2;

    typedef struct {
        logic [CW-1:0] col;
        logic [CW-1:0] row;
        logic [1:0]    sel;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_empty = 1'b0;
    logic          out_afull = 1'b0;
    logic          busy, done, in_rd_en, cap_en, line_rd_en, out_valid;
    logic [1:0]    out_sel;
    logic [CW-1:0] out_col, out_row;

    logic          start2 = 1'b0;
    logic          busy2, done2, in_rd_en2, cap_en2, line_rd_en2, out_valid2;
    logic [1:0]    out_sel2;
    logic [CW-1:0] out_col2, out_row2;

    always #5 clk = ~clk;

    upsample_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .in_empty(in_empty), .in_rd_en(in_rd_en), .cap_en(cap_en),
        .line_rd_en(line_rd_en), .out_sel(out_sel), .out_afull(out_afull),
        .out_valid(out_valid), .out_col(out_col), .out_row(out_row)
    );

    upsample_frame_ctrl #(.IMG_WIDTH(W2), .IMG_HEIGHT(H2), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .in_empty(1'b0), .in_rd_en(in_rd_en2), .cap_en(cap_en2),
        .line_rd_en(line_rd_en2), .out_sel(out_sel2), .out_afull(1'b0),
        .out_valid(out_valid2), .out_col(out_col2), .out_row(out_row2)
    );

    exp_t q[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;
    int vcount, rdcount, donecount;
    int vcount2, rdcount2, donecount2;
    bit done_seen, done2_seen, reached;
    bit prev_valid, prev_valid2;
    logic [CW-1:0] prev_col, prev_row, prev_col2, prev_row2;
    bit expect_stall = 1'b0;
    logic [CW-1:0] stall_col, stall_row;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference output order: even rows alternate LIVE/HOLD, odd rows LINE/HOLD.
    task automatic push_frame(input int w, input int h, input bit second);
        exp_t e;
        for (int r = 0; r < 2 * h; r++) begin
            for (int c = 0; c < 2 * w; c++) begin
                e.col = CW'(c);
                e.row = CW'(r);
                if (c % 2 == 1)      e.sel = E_HOLD;
                else if (r % 2 == 0) e.sel = E_LIVE;
                else                 e.sel = E_LINE;
                if (second) q2.push_back(e);
                else        q.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        chk("cap_matches_rd", {31'd0, cap_en}, {31'd0, in_rd_en});
        if (out_afull)
            chk("afull_no_strobe", {28'd0, out_valid, in_rd_en, cap_en, line_rd_en}, 32'd0);
        if (expect_stall) begin
            chk("stall_strobes", {28'd0, out_valid, in_rd_en, cap_en, line_rd_en}, 32'd0);
            chk("stall_col", 32'(out_col), 32'(stall_col));
            chk("stall_row", 32'(out_row), 32'(stall_row));
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("col", 32'(out_col), 32'(e.col));
                chk("row", 32'(out_row), 32'(e.row));
                chk("sel", 32'(out_sel), 32'(e.sel));
            end
            vcount++;
        end
        if (in_rd_en) rdcount++;
        if (done) begin
            donecount++;
            done_seen = 1'b1;
            chk("done_after_last", {prev_valid, 9'd0, prev_col, prev_row},
                {1'b1, 9'd0, CW'(2 * W - 1), CW'(2 * H - 1)});
        end
        prev_valid = out_valid;
        prev_col   = out_col;
        prev_row   = out_row;

        if (out_valid2) begin
            if (q2.size() == 0) begin
                chk("unexpected_valid2", {31'd0, out_valid2}, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("col2", 32'(out_col2), 32'(e.col));
                chk("row2", 32'(out_row2), 32'(e.row));
                chk("sel2", 32'(out_sel2), 32'(e.sel));
            end
            vcount2++;
        end
        if (in_rd_en2) rdcount2++;
        if (done2) begin
            donecount2++;
            done2_seen = 1'b1;
            chk("done2_after_last", {prev_valid2, 9'd0, prev_col2, prev_row2},
                {1'b1, 9'd0, CW'(2 * W2 - 1), CW'(2 * H2 - 1)});
        end
        prev_valid2 = out_valid2;
        prev_col2   = out_col2;
        prev_row2   = out_row2;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic tick();
        #1;
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        push_frame(W, H, 1'b0);
        vcount = 0; rdcount = 0; donecount = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_frame(input int budget);
        done_seen = 1'b0;
        for (int i = 0; i < budget && !done_seen; i++) tick();
        chk("done_timeout", {31'd0, done_seen}, 32'd1);
        chk("busy_low_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic frame_totals(input string tag);
        chk({tag, "_valid_count"}, vcount, 4 * W * H);
        chk({tag, "_pop_count"}, rdcount, W * H);
        chk({tag, "_done_count"}, donecount, 1);
        chk({tag, "_queue_left"}, q.size(), 0);
    endtask

    task automatic wait_pos(input int col, input int row, input int budget);
        reached = 1'b0;
        for (int i = 0; i < budget && !reached; i++) begin
            if (out_col == CW'(col) && out_row == CW'(row)) reached = 1'b1;
            else tick();
        end
        chk("wait_pos_timeout", {31'd0, reached}, 32'd1);
    endtask

    task automatic stall_cycles(input int n);
        stall_col = out_col;
        stall_row = out_row;
        expect_stall = 1'b1;
        for (int i = 0; i < n; i++) tick();
        expect_stall = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        tick(); tick(); tick();
        chk("rst_strobes", {25'd0, busy, done, out_valid, in_rd_en, cap_en, line_rd_en, 1'b0},
            32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_col", 32'(out_col), 32'd0);
        chk("rst_row", 32'(out_row), 32'd0);
        rst = 1'b0;
        tick();

        // Plain frame
        start_frame();
        run_frame(200);
        frame_totals("plain");

        // FIFO runs dry in LIVE_P0 at column 2
        start_frame();
        wait_pos(2, 0, 50);
        in_empty = 1'b1;
        stall_cycles(5);
        in_empty = 1'b0;
        run_frame(200);
        frame_totals("empty_gap");

        // Backpressure in LIVE_P1 and in REPLAY_P0
        start_frame();
        wait_pos(1, 0, 50);
        out_afull = 1'b1;
        stall_cycles(3);
        out_afull = 1'b0;
        wait_pos(2, 1, 50);
        out_afull = 1'b1;
        stall_cycles(3);
        out_afull = 1'b0;
        run_frame(200);
        frame_totals("afull");

        // start while busy and during the DONE cycle is ignored
        start_frame();
        for (int i = 0; i < 6; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            tick();
            if (prev_valid && prev_col == CW'(2 * W - 1) && prev_row == CW'(2 * H - 1))
                reached = 1'b1;
        end
        chk("last_pixel_timeout", {31'd0, reached}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_seen_with_start", {31'd0, done_seen}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("idle_after_done_start", {30'd0, busy, out_valid}, 32'd0);
            tick();
        end
        frame_totals("restart_ignored");
        start_frame();
        run_frame(200);
        frame_totals("fresh_frame");

        // Reset mid-frame, then a clean frame
        start_frame();
        wait_pos(5, 1, 100);
        rst = 1'b1;
        tick();
        chk("abort_strobes", {25'd0, busy, done, out_valid, in_rd_en, cap_en, line_rd_en, 1'b0},
            32'd0);
        chk("abort_sel", 32'(out_sel), 32'd0);
        chk("abort_col", 32'(out_col), 32'd0);
        chk("abort_row", 32'(out_row), 32'd0);
        rst = 1'b0;
        q.delete();
        tick();
        start_frame();
        run_frame(200);
        frame_totals("after_abort");

        // Larger frame on the second instance
        push_frame(W2, H2, 1'b1);
        vcount2 = 0; rdcount2 = 0; donecount2 = 0; done2_seen = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("busy2_after_start", {31'd0, busy2}, 32'd1);
        for (int i = 0; i < 3000 && !done2_seen; i++) tick();
        chk("done2_timeout", {31'd0, done2_seen}, 32'd1);
        chk("busy2_low_after_done", {31'd0, busy2}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("big_valid_count", vcount2, 4 * W2 * H2);
        chk("big_pop_count", rdcount2, W2 * H2);
        chk("big_done_count", donecount2, 1);
        chk("big_queue_left", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
